// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
// Shared types and helpers for the Hamming(7,4) encode/decode stages.
//   codeword_t : [0:6]  d0..d3 in bits 0..3, parity p4/p5/p6 in bits 4..6
//   data_t     : [0:3]  d0..d3
//   syndrome_t : [2:0]  {s2,s1,s0}
//   syn_to_pos : maps a syndrome to the codeword bit to flip, or none
// ---------------------------------------------------------------------------
package hamming_pkg;

  typedef logic [0:6] codeword_t;
  typedef logic [0:3] data_t;
  typedef logic [2:0] syndrome_t;

  // Syndrome codes, named after the codeword bit they point at.
  localparam syndrome_t SYN_NONE = 3'b000;
  localparam syndrome_t SYN_B0   = 3'b011;
  localparam syndrome_t SYN_B1   = 3'b101;
  localparam syndrome_t SYN_B2   = 3'b110;
  localparam syndrome_t SYN_B3   = 3'b111;
  localparam syndrome_t SYN_P4   = 3'b001;
  localparam syndrome_t SYN_P5   = 3'b010;
  localparam syndrome_t SYN_P6   = 3'b100;

  // Frame word index width; covers FRAME_LEN up to 255.
  localparam int IDX_W = 8;

  typedef struct packed {
    logic       flip;  // 1: a bit must be flipped
    logic [2:0] pos;   // codeword bit index 0..6
  } flip_t;

  typedef enum logic {
    ST_IDLE,
    ST_IN_FRAME
  } frame_state_t;

  function automatic flip_t syn_to_pos(input syndrome_t syn);
    flip_t f;
    f = '{flip: 1'b1, pos: 3'd0};
    case (syn)
      SYN_B0:  f.pos = 3'd0;
      SYN_B1:  f.pos = 3'd1;
      SYN_B2:  f.pos = 3'd2;
      SYN_B3:  f.pos = 3'd3;
      SYN_P4:  f.pos = 3'd4;
      SYN_P5:  f.pos = 3'd5;
      SYN_P6:  f.pos = 3'd6;
      default: f = '{flip: 1'b0, pos: 3'd0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// ---------------------------------------------------------------------------
// hamming74_syndrome
// Purely combinational syndrome computation and single-bit correction.
//   i_codeword : received codeword [0:6]
//   o_syndrome : {s2,s1,s0}
//   o_data     : corrected data bits d0..d3 (parity-bit errors leave data as is)
// ---------------------------------------------------------------------------
module hamming74_syndrome
  import hamming_pkg::*;
(
  input  logic [0:6] i_codeword,
  output logic [2:0] o_syndrome,
  output logic [0:3] o_data
);

  flip_t      w_flip;
  logic [0:3] w_mask;

  assign o_syndrome = {i_codeword[6] ^ i_codeword[1] ^ i_codeword[2] ^ i_codeword[3],
                       i_codeword[5] ^ i_codeword[0] ^ i_codeword[2] ^ i_codeword[3],
                       i_codeword[4] ^ i_codeword[0] ^ i_codeword[1] ^ i_codeword[3]};

  assign w_flip = syn_to_pos(o_syndrome);

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_mask = '0;
    // Only data positions (pos < 4) touch the output; parity flips are no-ops here.
    if (w_flip.flip && !w_flip.pos[2]) w_mask[w_flip.pos[1:0]] = 1'b1;
  end

  assign o_data = i_codeword[0:3] ^ w_mask;

endmodule

// File: rtl/hamming74_decoder.sv
// ---------------------------------------------------------------------------
// hamming74_decoder
// Two-stage Hamming(7,4) decoder with frame tracking and correction counter.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in_valid    : byte_in carries a codeword
//   byte_in     : codeword [0:6]
//   cnt_clear   : synchronous clear of corr_cnt (wins over increment)
//   bits_out    : corrected data [0:3], held when out_valid is low
//   out_valid   : one-cycle strobe per decoded word
//   err_corr    : a single-bit error was corrected in the word on bits_out
//   syndrome    : syndrome of the word on bits_out, held when out_valid is low
//   frame_done  : strobe with the last word of each frame
//   frame_err   : any correction within the closing frame (only with frame_done)
//   corr_cnt    : saturating count of corrected words
// ---------------------------------------------------------------------------
module hamming74_decoder
  import hamming_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [0:6]       byte_in,
  input  logic             cnt_clear,
  output logic [0:3]       bits_out,
  output logic             out_valid,
  output logic             err_corr,
  output logic [2:0]       syndrome,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] corr_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic             r_s1_valid;
  codeword_t        r_s1_cw;
  frame_state_t     r_state;
  logic [IDX_W-1:0] r_word_idx;
  logic             r_acc;

  syndrome_t w_syn;
  data_t     w_data;
  logic      w_err;
  logic      w_last;

  // Stage 1: capture the incoming codeword.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_cw <= byte_in;
    end
  end

  hamming74_syndrome u_syndrome (
    .i_codeword (r_s1_cw),
    .o_syndrome (w_syn),
    .o_data     (w_data)
  );

  assign w_err  = (w_syn != SYN_NONE);
  assign w_last = (r_word_idx == LAST_IDX);

  // Stage 2: registered decode results.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      err_corr  <= 1'b0;
      bits_out  <= '0;
      syndrome  <= '0;
    end else begin
      out_valid <= r_s1_valid;
      err_corr  <= r_s1_valid && w_err;
      if (r_s1_valid) begin
        bits_out <= w_data;
        syndrome <= w_syn;
      end
    end
  end

  // Frame tracker; advances in the same edge that registers the stage-2 word,
  // so frame_done/frame_err line up with that word's out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_acc      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_s1_valid) begin
            if (w_last) begin
              // Only reachable with FRAME_LEN == 1: each word closes its own frame.
              frame_done <= 1'b1;
              frame_err  <= w_err;
            end else begin
              r_word_idx <= IDX_W'(1);
              r_acc      <= w_err;
              r_state    <= ST_IN_FRAME;
            end
          end
        end
        ST_IN_FRAME: begin
          if (r_s1_valid) begin
            if (w_last) begin
              frame_done <= 1'b1;
              frame_err  <= r_acc | w_err;
              r_word_idx <= '0;
              r_acc      <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_word_idx <= r_word_idx + IDX_W'(1);
              r_acc      <= r_acc | w_err;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating correction counter; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      corr_cnt <= '0;
    end else if (r_s1_valid && w_err && (corr_cnt != {CNT_W{1'b1}})) begin
      corr_cnt <= corr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming74_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming74_decoder
// Directed stimulus with a scoreboard: each driven word pushes its expected
// decode and frame flags; a negedge monitor pops and compares on out_valid.
// ---------------------------------------------------------------------------
module tb_hamming74_decoder;
  import hamming_pkg::*;

  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic [0:6]       byte_in   = '0;
  logic             cnt_clear = 1'b0;
  logic [0:3]       bits_out;
  logic             out_valid;
  logic             err_corr;
  logic [2:0]       syndrome;
  logic             frame_done;
  logic             frame_err;
  logic [CNT_W-1:0] corr_cnt;

  always #5 clk = ~clk;

  hamming74_decoder #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .byte_in    (byte_in),
    .cnt_clear  (cnt_clear),
    .bits_out   (bits_out),
    .out_valid  (out_valid),
    .err_corr   (err_corr),
    .syndrome   (syndrome),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .corr_cnt   (corr_cnt)
  );

  typedef struct {
    logic [0:3] d;
    logic [2:0] syn;
    logic       err;
    logic       fd;
    logic       fe;
    logic       clr;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_idx   = 0;
  logic m_acc   = 1'b0;
  int   m_cnt   = 0;

  // Syndrome expected for a single error at codeword position 0..6.
  logic [2:0] syn_tab [0:6] = '{3'b011, 3'b101, 3'b110, 3'b111, 3'b001, 3'b010, 3'b100};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:6] tb_encode(input logic [0:3] d);
    return {d, d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3], d[1] ^ d[2] ^ d[3]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Drive one codeword and push its expectation, advancing the frame model.
  task automatic send_raw(input logic [0:6] cw, input logic [0:3] d,
                          input logic [2:0] syn, input logic clr);
    exp_t e;
    e.d   = d;
    e.syn = syn;
    e.err = (syn != 3'b000);
    e.clr = clr;
    e.fd  = (m_idx == FRAME_LEN - 1);
    e.fe  = e.fd && (m_acc || e.err);
    if (e.fd) begin
      m_idx = 0;
      m_acc = 1'b0;
    end else begin
      m_idx++;
      m_acc = m_acc || e.err;
    end
    q.push_back(e);
    byte_in  = cw;
    in_valid = 1'b1;
    step();
  endtask

  task automatic send(input logic [0:3] d, input int flip, input logic clr);
    logic [0:6] cw;
    cw = tb_encode(d);
    if (flip >= 0) cw[flip] = ~cw[flip];
    send_raw(cw, d, (flip >= 0) ? syn_tab[flip] : 3'b000, clr);
  endtask

  // Pulse cnt_clear on the edge that outputs the word sent just before.
  task automatic clear_step;
    in_valid  = 1'b0;
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    in_valid = 1'b1;           // must be ignored while reset is high
    byte_in  = 7'b1111111;
    step();
    q.delete();
    m_idx = 0;
    m_acc = 1'b0;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_bits_out",   bits_out,   0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_err_corr",   err_corr,   0);
    check("rst_syndrome",   syndrome,   0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err",  frame_err,  0);
    check("rst_corr_cnt",   corr_cnt,   0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_cnt = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e_mon = q.pop_front();
        if (e_mon.clr)                        m_cnt = 0;
        else if (e_mon.err && m_cnt < CNT_MAX) m_cnt++;
        check("bits_out",   bits_out,   e_mon.d);
        check("syndrome",   syndrome,   e_mon.syn);
        check("err_corr",   err_corr,   e_mon.err);
        check("frame_done", frame_done, e_mon.fd);
        check("frame_err",  frame_err,  e_mon.fe);
        check("corr_cnt",   corr_cnt,   m_cnt);
      end
    end else begin
      check("idle_strobes", {err_corr, frame_done, frame_err}, 0);
    end
  end

  initial begin
    do_reset();

    // Clean word and two-cycle latency.
    send_raw(7'b1011010, 4'b1011, 3'b000, 1'b0);
    in_valid = 1'b0;
    check("lat_edge1_out_valid", out_valid, 0);
    step();
    check("lat_edge2_out_valid", out_valid, 1);
    check("lat_edge2_bits_out",  bits_out,  4'b1011);

    // Data-bit and parity-bit errors.
    send_raw(7'b1111010, 4'b1011, 3'b101, 1'b0);
    send_raw(7'b1011000, 4'b1011, 3'b010, 1'b0);
    idle(3);
    check("cnt_after_two_errors", corr_cnt, 2);
    check("hold_bits_out", bits_out, 4'b1011);
    check("hold_syndrome", syndrome, 3'b010);

    // Every error position once.
    do_reset();
    for (int i = 0; i < 7; i++) send(4'(i + 5), i, 1'b0);
    idle(3);

    // Frames of 4, back-to-back, error only in word 6.
    do_reset();
    for (int k = 0; k < 8; k++) send(4'(k + 3), (k == 5) ? 2 : -1, 1'b0);
    idle(3);

    // Same frames with a 3-cycle gap inside the first frame.
    for (int k = 0; k < 8; k++) begin
      send(4'(k + 3), (k == 5) ? 2 : -1, 1'b0);
      if (k == 1) idle(3);
    end
    idle(3);

    // Saturation then clear coinciding with an erroneous word.
    do_reset();
    for (int k = 0; k < 5; k++) send(4'(k + 1), k, 1'b0);
    send(4'hA, 6, 1'b1);
    clear_step();
    idle(3);
    check("cnt_after_clear", corr_cnt, 0);

    // Reset mid-frame: two words out, third in flight.
    do_reset();
    send(4'h1, -1, 1'b0);
    send(4'h2, -1, 1'b0);
    send(4'h3, -1, 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) send(4'(k + 8), -1, 1'b0);
    idle(1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    check("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
